seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Multi-cycle, parametrised successor to the single-cycle combinational ALU. It keeps the same 16-entry opcode map, and adds:
- registered NZCV flags
- ARM-style conditional execution
- real ADD/SUB/CMP/logic datapaths
- an iterative shift-add multiplier
- a start/busy/done handshake toward the execute-stage controller

Parameters:
WIDTH, 32, datapath width of source, result and multiplier.
IMM_W, 16, immediate field width. IMM_W <= WIDTH.
SHAMT_W, 5, shift-amount width, equal to log2(WIDTH). Shift amount is imm[SHAMT_W+2:3].

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only when busy=0
op_code  input  4  operation, same map as the existing ALU
conditional  input  4  condition code checked against the flags register
s_bit  input  1  when 1, the operation updates flags
source_1  input  WIDTH  operand A
source_2  input  WIDTH  operand B
immediate_value  input  IMM_W  immediate n / shift field
busy  output  1  high from the accept edge until the done edge
done  output  1  one-cycle pulse: result/flags valid
cond_pass  output  1  valid with done; 0 means the instruction was squashed
result  output  WIDTH  registered result
flags  output  4  registered {N,Z,C,V}

Behaviour:
- Reset (async): result=0, flags=0000, busy=0, done=0, cond_pass=0, FSM=IDLE, multiplier registers cleared. Reset mid-MUL aborts the operation with no done pulse.
- Accept: at a rising edge with start=1 and busy=0, latch op_code, conditional, s_bit, operands and imm. Latch also the condition result, evaluated on the current flags.
- start while busy=1 is ignored; no queueing.
- FSM states:
  - IDLE → EXEC on accept for any op except MUL with condition passing.
  - IDLE → MUL on accept for MUL with condition passing.
  - EXEC → IDLE after one cycle, asserting done.
  - MUL → IDLE after the last iteration, asserting done.
  - A failed condition always takes the EXEC path.
- Latency: done rises on the edge after accept for single-cycle ops, giving latency 1.
- MUL latency is n+1, where n = WIDTH iterations. Each iteration: if the multiplier LSB is set, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1.
- Condition codes: 0 EQ, 1 NE, 2 CS, 3 CC, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, 10 GE, 11 LT, 12 GT, 13 LE, 14 AL, 15 AL.
- Condition fail: result and flags hold; done pulses with cond_pass=0.
- Opcode results:
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 MUL: low WIDTH bits of A*B
  - 3 ORR, 4 AND, 5 EOR: bitwise
  - 6 MOV: zero-extended imm
  - 7 MOV: A
  - 8 LSR, 9 LSL: logical shift of A by shamt
  - 10 ROR: rotate right of A by shamt
  - 11 CMP: A−B; flags only, result holds
  - 12 ADR: zero-extended imm
  - 13 LDR, 14 STR, 15 NOP: result holds
- Flags update when the condition passes and (s_bit=1 or op=CMP). Ops 13-15 never update flags.
  - N = result MSB; Z = (result==0).
  - ADD: C = carry out; V = signed overflow.
  - SUB/CMP: C = no borrow (A>=B unsigned); V = signed overflow of A−B.
  - Shifts/rotate: C = last bit shifted out if shamt≠0, else unchanged. V unchanged.
  - Logic, MOV, ADR, MUL: C and V unchanged.
- Flag results for CMP are computed from A−B, not from the held result.
- The flags output used by condition evaluation is the registered value; there is no forwarding from an in-flight op.

Optional Feature:
Macro: SEQ_ALU_MUL_EARLY_EXIT_EN.
- Defined: n = max(1, index of highest set bit of source_2 + 1). MUL terminates once the remaining multiplier bits are zero; result is identical.
- Not defined: n = WIDTH always; MUL latency is fixed at WIDTH+1.

Test Plan:
- Reset asserted mid-MUL: outputs go to 0 immediately, no done; next ADD 2+3 → result=5 after 1 cycle.
- ADD, s_bit=1, A=32'h7FFFFFFF, B=1 → result 32'h80000000, flags N=1 Z=0 C=0 V=1, done at cycle +1.
- CMP A=5, B=5, s_bit=0 → flags Z=1 C=1 N=0 V=0, result unchanged. Then MOV imm 16'h1234 with conditional=NE → cond_pass=0, result unchanged.
- MUL A=3, B=5 → result 15, done after 33 cycles. With SEQ_ALU_MUL_EARLY_EXIT_EN → done after 4 cycles. start pulses while busy are ignored.
- ROR A=32'h00000001, imm[7:3]=1, s_bit=1 → result 32'h80000000, C=1, N=1. LSL with shamt=0 leaves C unchanged.
- NOP, LDR, STR back-to-back after a result of 5 → result stays 5, flags unchanged, done pulses each op.

Source files
------------

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with NZCV flags, conditional execution and shift-add multiplier
// Optional: SEQ_ALU_MUL_EARLY_EXIT_EN stops MUL once the remaining multiplier bits are zero.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int IMM_W   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op_code,
  input  logic [3:0]         conditional,
  input  logic               s_bit,
  input  logic [WIDTH-1:0]   source_1,
  input  logic [WIDTH-1:0]   source_2,
  input  logic [IMM_W-1:0]   immediate_value,
  output logic               busy,
  output logic               done,
  output logic               cond_pass,
  output logic [WIDTH-1:0]   result,
  output logic [3:0]         flags
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_ORR = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_EOR = 4'd5,  OP_MVI = 4'd6,  OP_MOV = 4'd7;
  localparam logic [3:0] OP_LSR = 4'd8,  OP_LSL = 4'd9,  OP_ROR = 4'd10, OP_CMP = 4'd11;
  localparam logic [3:0] OP_ADR = 4'd12;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t state_q, state_d;

  logic [3:0]         op_q;
  logic               s_q;
  logic               cond_ok_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IMM_W-1:0]   imm_q;
  logic [WIDTH-1:0]   acc_q, mcand_q, mplier_q;
  logic [CNT_W-1:0]   cnt_q;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = !z;
      4'd2:    cond_eval = cy;
      4'd3:    cond_eval = !cy;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = !n;
      4'd6:    cond_eval = v;
      4'd7:    cond_eval = !v;
      4'd8:    cond_eval = cy && !z;
      4'd9:    cond_eval = !cy || z;
      4'd10:   cond_eval = (n == v);
      4'd11:   cond_eval = (n != v);
      4'd12:   cond_eval = !z && (n == v);
      4'd13:   cond_eval = z || (n != v);
      default: cond_eval = 1'b1;
    endcase
  endfunction

  logic accept, pass_now, mul_last;

  assign busy     = (state_q != IDLE);
  assign accept   = start && !busy;
  assign pass_now = cond_eval(conditional, flags);

`ifdef SEQ_ALU_MUL_EARLY_EXIT_EN
  assign mul_last = (cnt_q != '0) && (mplier_q == '0);
`else
  assign mul_last = (cnt_q == CNT_W'(WIDTH));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (op_code == OP_MUL && pass_now) ? MUL : EXEC;
      EXEC:    state_d = IDLE;
      MUL:     if (mul_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [WIDTH:0]     sum, diff;
  logic [SHAMT_W-1:0] shamt, lsr_idx, lsl_idx;
  logic [SHAMT_W:0]   inv_shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, wr_res, upd_flags;
  logic [3:0]         flags_new;

  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign diff      = {1'b0, a_q} - {1'b0, b_q};
  assign shamt     = imm_q[SHAMT_W+2:3];
  assign inv_shamt = (SHAMT_W+1)'(WIDTH) - {1'b0, shamt};
  assign lsr_idx   = shamt - SHAMT_W'(1);
  assign lsl_idx   = inv_shamt[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = flags[1];
    alu_v   = flags[0];
    case (op_q)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = !diff[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_ORR: alu_res = a_q | b_q;
      OP_AND: alu_res = a_q & b_q;
      OP_EOR: alu_res = a_q ^ b_q;
      OP_MVI, OP_ADR: alu_res = WIDTH'(imm_q);
      OP_MOV: alu_res = a_q;
      OP_LSR: begin
        alu_res = a_q >> shamt;
        if (shamt != '0) alu_c = a_q[lsr_idx];
      end
      OP_LSL: begin
        alu_res = a_q << shamt;
        if (shamt != '0) alu_c = a_q[lsl_idx];
      end
      OP_ROR: begin
        // Shift by WIDTH (shamt=0) yields 0 on the left term, so the rotate degenerates to A.
        alu_res = (a_q >> shamt) | (a_q << inv_shamt);
        if (shamt != '0) alu_c = alu_res[WIDTH-1];
      end
      default: alu_res = '0;
    endcase
  end

  assign flags_new = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
  assign wr_res    = (op_q != OP_CMP) && (op_q <= OP_ADR);
  assign upd_flags = (s_q || op_q == OP_CMP) && (op_q <= OP_ADR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      flags     <= '0;
      done      <= 1'b0;
      cond_pass <= 1'b0;
      op_q      <= '0;
      s_q       <= 1'b0;
      cond_ok_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          op_q      <= op_code;
          s_q       <= s_bit;
          cond_ok_q <= pass_now;
          a_q       <= source_1;
          b_q       <= source_2;
          imm_q     <= immediate_value;
          acc_q     <= '0;
          mcand_q   <= source_1;
          mplier_q  <= source_2;
          cnt_q     <= '0;
        end
        EXEC: begin
          done      <= 1'b1;
          cond_pass <= cond_ok_q;
          if (cond_ok_q) begin
            if (wr_res)    result <= alu_res;
            if (upd_flags) flags  <= flags_new;
          end
        end
        MUL: begin
          if (mul_last) begin
            done      <= 1'b1;
            cond_pass <= 1'b1;
            result    <= acc_q;
            if (s_q) flags <= {acc_q[WIDTH-1], (acc_q == '0), flags[1:0]};
          end else begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed-vector bench for seq_alu
module tb_seq_alu;

  logic        clk, rst, start, s_bit;
  logic [3:0]  op_code, conditional;
  logic [31:0] source_1, source_2;
  logic [15:0] immediate_value;
  logic        busy, done, cond_pass;
  logic [31:0] result;
  logic [3:0]  flags;

  int vectors = 0;
  int miscompares = 0;

`ifdef SEQ_ALU_MUL_EARLY_EXIT_EN
  localparam int MUL_LAT_5   = 4;
  localparam int MUL_LAT_100 = 10;
`else
  localparam int MUL_LAT_5   = 33;
  localparam int MUL_LAT_100 = 33;
`endif

  seq_alu #(.WIDTH(32), .IMM_W(16), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op_code(op_code), .conditional(conditional),
    .s_bit(s_bit), .source_1(source_1), .source_2(source_2),
    .immediate_value(immediate_value), .busy(busy), .done(done), .cond_pass(cond_pass),
    .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller sits at a negedge; the accept edge falls inside this task.
  task automatic issue(input logic [3:0] op, input logic [3:0] c, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm);
    op_code = op; conditional = c; s_bit = s;
    source_1 = a; source_2 = b; immediate_value = imm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 100);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op_code = '0; conditional = 4'd14; s_bit = 1'b0;
    source_1 = '0; source_2 = '0; immediate_value = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({result, flags, busy, done, cond_pass} !== 39'd0) begin
      $display("FAIL reset_state: got res=%h flags=%b busy=%b done=%b cp=%b want all zero",
               result, flags, busy, done, cond_pass);
      miscompares++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_overflow;
    int cyc;
    issue(4'd0, 4'd14, 1'b1, 32'h7FFF_FFFF, 32'h1, 16'h0);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL add_busy: got busy=%b done=%b want busy=1 done=0", busy, done); miscompares++;
    end
    wait_done(cyc);
    vectors++;
    if (cyc !== 1) begin $display("FAIL add_latency: got %0d want 1", cyc); miscompares++; end
    vectors++;
    if (result !== 32'h8000_0000) begin $display("FAIL add_result: got %h want 80000000", result); miscompares++; end
    vectors++;
    if (flags !== 4'b1001 || cond_pass !== 1'b1) begin
      $display("FAIL add_flags: got flags=%b cp=%b want 1001 cp=1", flags, cond_pass); miscompares++;
    end
  endtask

  task automatic test_reset_mid_mul;
    int cyc, dones;
    issue(4'd2, 4'd14, 1'b0, 32'd3, 32'd5, 16'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({result, flags, busy, done, cond_pass} !== 39'd0) begin
      $display("FAIL midmul_reset: got res=%h flags=%b busy=%b done=%b want all zero",
               result, flags, busy, done); miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    vectors++;
    if (dones !== 0) begin $display("FAIL midmul_no_done: got %0d dones want 0", dones); miscompares++; end
    issue(4'd0, 4'd14, 1'b0, 32'd2, 32'd3, 16'h0);
    wait_done(cyc);
    vectors++;
    if (cyc !== 1 || result !== 32'd5) begin
      $display("FAIL post_reset_add: got lat=%0d res=%h want lat=1 res=5", cyc, result); miscompares++;
    end
  endtask

  task automatic test_cmp_cond;
    int cyc;
    issue(4'd11, 4'd14, 1'b0, 32'd5, 32'd5, 16'h0);
    wait_done(cyc);
    vectors++;
    if (flags !== 4'b0110 || result !== 32'd5) begin
      $display("FAIL cmp_eq: got flags=%b res=%h want 0110 res=5", flags, result); miscompares++;
    end
    issue(4'd6, 4'd1, 1'b0, 32'd0, 32'd0, 16'h1234);
    wait_done(cyc);
    vectors++;
    if (cyc !== 1 || cond_pass !== 1'b0 || result !== 32'd5) begin
      $display("FAIL cond_ne_squash: got lat=%0d cp=%b res=%h want lat=1 cp=0 res=5", cyc, cond_pass, result);
      miscompares++;
    end
    issue(4'd6, 4'd0, 1'b0, 32'd0, 32'd0, 16'h1234);
    wait_done(cyc);
    vectors++;
    if (cond_pass !== 1'b1 || result !== 32'h1234 || flags !== 4'b0110) begin
      $display("FAIL cond_eq_pass: got cp=%b res=%h flags=%b want cp=1 res=1234 flags=0110",
               cond_pass, result, flags); miscompares++;
    end
  endtask

  task automatic test_mul;
    int cyc, busy_bad, extra;
    issue(4'd2, 4'd14, 1'b0, 32'd3, 32'd5, 16'h0);
    cyc = 0; busy_bad = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        if (busy !== 1'b1) busy_bad++;
        if (cyc == 1) begin
          op_code = 4'd0; source_1 = 32'd100; source_2 = 32'd1; start = 1'b1;
        end
        if (cyc == 2) start = 1'b0;
      end
    end while (!done && cyc < 100);
    start = 1'b0;
    vectors++;
    if (cyc !== MUL_LAT_5) begin $display("FAIL mul_latency: got %0d want %0d", cyc, MUL_LAT_5); miscompares++; end
    vectors++;
    if (result !== 32'd15 || cond_pass !== 1'b1 || busy_bad !== 0) begin
      $display("FAIL mul_result: got res=%h cp=%b busy_drops=%0d want res=f cp=1 drops=0",
               result, cond_pass, busy_bad); miscompares++;
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    vectors++;
    if (extra !== 0 || result !== 32'd15) begin
      $display("FAIL mul_ignore_start: got extra=%0d res=%h want extra=0 res=f", extra, result); miscompares++;
    end
    issue(4'd2, 4'd14, 1'b1, 32'h1234_5678, 32'h100, 16'h0);
    wait_done(cyc);
    vectors++;
    if (cyc !== MUL_LAT_100 || result !== 32'h3456_7800 || flags !== 4'b0010) begin
      $display("FAIL mul_shift8: got lat=%0d res=%h flags=%b want lat=%0d res=34567800 flags=0010",
               cyc, result, flags, MUL_LAT_100); miscompares++;
    end
  endtask

  task automatic test_shifts;
    int cyc;
    issue(4'd10, 4'd14, 1'b1, 32'h1, 32'h0, 16'h0008);
    wait_done(cyc);
    vectors++;
    if (result !== 32'h8000_0000 || flags !== 4'b1010) begin
      $display("FAIL ror1: got res=%h flags=%b want 80000000 1010", result, flags); miscompares++;
    end
    issue(4'd9, 4'd14, 1'b1, 32'h3, 32'h0, 16'h0000);
    wait_done(cyc);
    vectors++;
    if (result !== 32'h3 || flags !== 4'b0010) begin
      $display("FAIL lsl0_keep_c: got res=%h flags=%b want 00000003 0010", result, flags); miscompares++;
    end
    issue(4'd9, 4'd14, 1'b1, 32'h0800_0001, 32'h0, 16'h0020);
    wait_done(cyc);
    vectors++;
    if (result !== 32'h8000_0010 || flags !== 4'b1000) begin
      $display("FAIL lsl4: got res=%h flags=%b want 80000010 1000", result, flags); miscompares++;
    end
    issue(4'd8, 4'd14, 1'b1, 32'h3, 32'h0, 16'h0008);
    wait_done(cyc);
    vectors++;
    if (result !== 32'h1 || flags !== 4'b0010) begin
      $display("FAIL lsr1: got res=%h flags=%b want 00000001 0010", result, flags); miscompares++;
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [3:0] ops [3];
    ops[0] = 4'd15; ops[1] = 4'd13; ops[2] = 4'd14;
    issue(4'd0, 4'd14, 1'b0, 32'd2, 32'd3, 16'h0);
    wait_done(cyc);
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 4'd14, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF);
      wait_done(cyc);
      vectors++;
      if (cyc !== 1 || result !== 32'd5 || flags !== 4'b0010 || cond_pass !== 1'b1) begin
        $display("FAIL b2b_op%0d: got lat=%0d res=%h flags=%b cp=%b want lat=1 res=5 flags=0010 cp=1",
                 ops[i], cyc, result, flags, cond_pass); miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_reset_mid_mul();
    test_cmp_cond();
    test_mul();
    test_shifts();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
